pll_mode_sequencer: RTL and testbench

- Management-side controller that retunes a reconfigurable fractional PLL between NUM_MODES preset clock configurations, e.g. NTSC and PAL system/2x clocks.
- Holds a per-mode table of N, M and fractional-K values plus NUM_COUNTERS output-counter settings.
- On request it writes the selected mode to the PLL reconfiguration management port in polling mode, issues START, then waits for lock.
- Sits between the core's video-standard select logic and the PLL reconfig block, on the PLL reference clock.

---
 rtl/pll_mode_sequencer_if.sv | 25 ++
 rtl/pll_mode_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_pll_mode_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_mode_sequencer_if.sv
// PLL reconfiguration management port: sequencer is master, reconfig block is slave.
// Slave stalls a write by holding mgmt_waitrequest high.
interface pll_mode_sequencer_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_read,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_read,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_mode_sequencer.sv
// Retunes a fractional PLL to one of NUM_MODES presets: 5+NUM_COUNTERS registered writes, then waits for lock.
// First write one cycle after req; each write held until mgmt_waitrequest is low; req while busy kept one deep.
module pll_mode_sequencer #(
  parameter int NUM_MODES    = 2,
  parameter int NUM_COUNTERS = 2,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int MW           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  parameter int ENTRY_W      = 68 + 18 * NUM_COUNTERS
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic [NUM_MODES*ENTRY_W-1:0]   cfg_table,
  input  logic [MW-1:0]                  mode_sel,
  input  logic                           req,
  input  logic                           force_req,
  pll_mode_sequencer_if.master           mgmt,
  input  logic                           pll_locked,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [MW-1:0]                  cur_mode,
  output logic                           cfg_valid
);

  localparam int TMAX          = (LOCK_TIMEOUT > 32) ? LOCK_TIMEOUT : 32;
  localparam int TW            = $clog2(TMAX + 1);
  localparam int C_LSB         = 68;
  localparam int LOCK_FALLBACK = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_N,
    S_WR_M,
    S_WR_C,
    S_WR_K,
    S_WR_START,
    S_WAIT_LOCK
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [ENTRY_W-1:0]   shadow_q, shadow_d;
  logic [MW-1:0]        tgt_mode_q, tgt_mode_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [MW-1:0]        pend_mode_q, pend_mode_d;
  logic                 pend_force_q, pend_force_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 seen_low_q, seen_low_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [MW-1:0]        cur_mode_q, cur_mode_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 wr_q, wr_d;
  logic [5:0]           addr_q, addr_d;
  logic [31:0]          data_q, data_d;

  logic                 wr_cmpl;
  logic                 eval_vld;
  logic [MW-1:0]        eval_mode;
  logic                 eval_force;

  assign wr_cmpl = wr_q && !mgmt.mgmt_waitrequest;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    tgt_mode_d   = tgt_mode_q;
    pend_vld_d   = pend_vld_q;
    pend_mode_d  = pend_mode_q;
    pend_force_d = pend_force_q;
    timer_d      = timer_q;
    seen_low_d   = seen_low_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cur_mode_d   = cur_mode_q;
    cfg_valid_d  = cfg_valid_q;
    eval_vld     = 1'b0;
    eval_mode    = mode_sel;
    eval_force   = force_req;

    // A fresh req in IDLE beats a stored one; req while busy replaces any stored one.
    if (state_q == S_IDLE) begin
      pend_vld_d = 1'b0;
      if (req) begin
        eval_vld = 1'b1;
      end else if (pend_vld_q) begin
        eval_vld   = 1'b1;
        eval_mode  = pend_mode_q;
        eval_force = pend_force_q;
      end
    end else if (req) begin
      pend_vld_d   = 1'b1;
      pend_mode_d  = mode_sel;
      pend_force_d = force_req;
    end

    unique case (state_q)
      S_IDLE: begin
        if (eval_vld) begin
          if (int'(eval_mode) >= NUM_MODES) begin
            err_d = 1'b1;
          end else if (eval_mode == cur_mode_q && cfg_valid_q && !eval_force) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_WR_MODE;
            tgt_mode_d = eval_mode;
            shadow_d   = cfg_table[int'(eval_mode)*ENTRY_W +: ENTRY_W];
          end
        end
      end
      S_WR_MODE: if (wr_cmpl) state_d = S_WR_N;
      S_WR_N:    if (wr_cmpl) state_d = S_WR_M;
      S_WR_M:    if (wr_cmpl) state_d = S_WR_C;
      S_WR_C: begin
        if (wr_cmpl) begin
          if (idx_q == 5'(NUM_COUNTERS - 1)) begin
            idx_d   = '0;
            state_d = S_WR_K;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_WR_K: if (wr_cmpl) state_d = S_WR_START;
      S_WR_START: begin
        if (wr_cmpl) begin
          state_d     = S_WAIT_LOCK;
          timer_d     = TW'(1);
          seen_low_d  = 1'b0;
          cfg_valid_d = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        timer_d = timer_q + TW'(1);
        if (!pll_locked) seen_low_d = 1'b1;
        // Without an observed low, trust a high lock only once the PLL has had time to drop it.
        if (pll_locked && (seen_low_q || timer_q >= TW'(LOCK_FALLBACK))) begin
          done_d      = 1'b1;
          cur_mode_d  = tgt_mode_q;
          cfg_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q >= TW'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered, so decode them from the next-state view.
  always_comb begin
    wr_d   = 1'b0;
    addr_d = 6'h00;
    data_d = 32'h0;
    unique case (state_d)
      S_WR_MODE:  begin wr_d = 1'b1; addr_d = 6'h00; data_d = 32'd1; end
      S_WR_N:     begin wr_d = 1'b1; addr_d = 6'h03; data_d = {14'b0, shadow_d[17:0]}; end
      S_WR_M:     begin wr_d = 1'b1; addr_d = 6'h04; data_d = {14'b0, shadow_d[35:18]}; end
      S_WR_C: begin
        wr_d   = 1'b1;
        addr_d = 6'h05;
        data_d = {9'b0, idx_d, shadow_d[C_LSB + 18*int'(idx_d) +: 18]};
      end
      S_WR_K:     begin wr_d = 1'b1; addr_d = 6'h07; data_d = shadow_d[67:36]; end
      S_WR_START: begin wr_d = 1'b1; addr_d = 6'h02; data_d = 32'd1; end
      default:    begin wr_d = 1'b0; end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      tgt_mode_q   <= '0;
      pend_vld_q   <= 1'b0;
      pend_mode_q  <= '0;
      pend_force_q <= 1'b0;
      timer_q      <= '0;
      seen_low_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cur_mode_q   <= '0;
      cfg_valid_q  <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      tgt_mode_q   <= tgt_mode_d;
      pend_vld_q   <= pend_vld_d;
      pend_mode_q  <= pend_mode_d;
      pend_force_q <= pend_force_d;
      timer_q      <= timer_d;
      seen_low_q   <= seen_low_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cur_mode_q   <= cur_mode_d;
      cfg_valid_q  <= cfg_valid_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign mgmt.mgmt_write     = wr_q;
  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_writedata = data_q;
  assign mgmt.mgmt_read      = 1'b0;
  assign busy                = (state_q != S_IDLE);
  assign done                = done_q;
  assign err                 = err_q;
  assign cur_mode            = cur_mode_q;
  assign cfg_valid           = cfg_valid_q;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Randomized bench for pll_mode_sequencer: a transaction-level model predicts write lists and done/err outcomes.
// The reconfig slave is emulated with random or directed waitrequest stalls.
module tb_pll_mode_sequencer;
  localparam int NM = 3;
  localparam int NC = 2;
  localparam int LT = 64;
  localparam int MW = 2;
  localparam int EW = 68 + 18 * NC;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic              refclk = 1'b0;
  logic              rst_n;
  logic [NM*EW-1:0]  cfg_table;
  logic [MW-1:0]     mode_sel;
  logic              req;
  logic              force_req;
  logic              pll_locked;
  logic              busy, done, err, cfg_valid;
  logic [MW-1:0]     cur_mode;

  pll_mode_sequencer_if mif();

  pll_mode_sequencer #(
    .NUM_MODES(NM), .NUM_COUNTERS(NC), .LOCK_TIMEOUT(LT)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_table(cfg_table), .mode_sel(mode_sel),
    .req(req), .force_req(force_req), .mgmt(mif), .pll_locked(pll_locked),
    .busy(busy), .done(done), .err(err), .cur_mode(cur_mode), .cfg_valid(cfg_valid)
  );

  always #5 refclk = ~refclk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [17:0] t_n [NM];
  logic [17:0] t_m [NM];
  logic [31:0] t_k [NM];
  logic [17:0] t_c [NM][NC];

  int  m_cur = 0;
  bit  m_valid = 0;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  stall_pct = 0;
  bit  m_stall_en = 0;
  int  m_stall_cnt = 0;
  int  m_cycles = 0;
  bit  scramble = 0;
  int  last_icyc, last_f, last_s;

  bit          stall_prev = 0;
  logic [5:0]  prev_addr;
  logic [31:0] prev_data;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave emulation and bus observation.
  always @(negedge refclk) begin
    cyc = cyc + 1;
    if (rst_n && stall_prev) begin
      chk_eq("stall_hold_wr", mif.mgmt_write, 1);
      chk_eq("stall_hold_addr", mif.mgmt_address, prev_addr);
      chk_eq("stall_hold_data", mif.mgmt_writedata, prev_data);
    end
    if (done || err) chk_eq("done_err_excl", done & err, 0);
    if (mif.mgmt_write && mif.mgmt_address == 6'h04) m_cycles++;
    if (m_stall_en && mif.mgmt_write && mif.mgmt_address == 6'h04 && m_stall_cnt < 3) begin
      mif.mgmt_waitrequest = 1'b1;
      m_stall_cnt++;
    end else begin
      mif.mgmt_waitrequest = ($urandom_range(99) < stall_pct);
    end
    if (rst_n && mif.mgmt_write && !mif.mgmt_waitrequest)
      obs_q.push_back('{mif.mgmt_address, mif.mgmt_writedata, cyc});
    stall_prev = mif.mgmt_write && mif.mgmt_waitrequest;
    prev_addr  = mif.mgmt_address;
    prev_data  = mif.mgmt_writedata;
  end

  task automatic step();
    @(negedge refclk);
    #1;
  endtask

  task automatic issue(input int mode, input bit frc);
    mode_sel  = MW'(mode);
    force_req = frc;
    req       = 1'b1;
    step();
    req       = 1'b0;
  endtask

  task automatic build_exp(input int m);
    exp_q.delete();
    exp_q.push_back('{6'h00, 32'd1, 0});
    exp_q.push_back('{6'h03, {14'b0, t_n[m]}, 0});
    exp_q.push_back('{6'h04, {14'b0, t_m[m]}, 0});
    for (int c = 0; c < NC; c++)
      exp_q.push_back('{6'h05, {9'b0, 5'(c), t_c[m][c]}, 0});
    exp_q.push_back('{6'h07, t_k[m], 0});
    exp_q.push_back('{6'h02, 32'd1, 0});
  endtask

  task automatic wait_evt(input int budget, output bit gd, output bit ge, output int at);
    gd = 0; ge = 0; at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done || err) begin
        gd = done; ge = err; at = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic collect(output int s_cyc, output int f_cyc);
    int  n;
    wr_t o, e;
    n = exp_q.size();
    s_cyc = -1; f_cyc = -1;
    for (int i = 0; i < 400 && obs_q.size() < n; i++) step();
    chk_eq("wr_count", obs_q.size(), n);
    for (int i = 0; i < n && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk_eq("wr_addr", o.addr, e.addr);
      chk_eq("wr_data", o.data, e.data);
      if (i == 0) f_cyc = o.cyc;
      s_cyc = o.cyc;
    end
    exp_q.delete();
  endtask

  // lock_mode: 0 = lock toggles low then high, 1 = never locks, 2 = lock stays high throughout.
  task automatic finish_lock(input int mode, input int s, input int lock_mode);
    bit gd, ge;
    int at, l;
    if (lock_mode == 1) begin
      wait_evt(LT + 40, gd, ge, at);
      chk_eq("to_err", ge, 1);
      chk_eq("to_cycle", at - s, LT);
      chk_eq("to_cfg_valid", cfg_valid, 0);
      chk_eq("to_cur_mode", cur_mode, m_cur);
      chk_eq("to_busy", busy, 0);
      m_valid = 0;
    end else begin
      if (lock_mode == 0) begin
        repeat ($urandom_range(2, 12)) step();
        pll_locked = 1'b1;
        l = cyc;
        wait_evt(20, gd, ge, at);
        chk_eq("lock_done_cycle", at, l + 1);
      end else begin
        wait_evt(60, gd, ge, at);
        chk_eq("fallback_late", (at - s) > 16, 1);
      end
      chk_eq("seq_done", gd, 1);
      chk_eq("seq_cur_mode", cur_mode, mode);
      chk_eq("seq_cfg_valid", cfg_valid, 1);
      chk_eq("seq_busy", busy, 0);
      m_cur = mode;
      m_valid = 1;
    end
  endtask

  task automatic do_seq(input int mode, input bit frc, input int lock_mode);
    logic [NM*EW-1:0] saved;
    obs_q.delete();
    build_exp(mode);
    pll_locked = (lock_mode == 2);
    last_icyc = cyc;
    issue(mode, frc);
    saved = cfg_table;
    if (scramble) cfg_table = ~cfg_table;
    collect(last_s, last_f);
    cfg_table = saved;
    finish_lock(mode, last_s, lock_mode);
  endtask

  task automatic do_req(input int mode, input bit frc);
    bit gd, ge;
    int at, icyc;
    if (mode >= NM || (mode == m_cur && m_valid && !frc)) begin
      obs_q.delete();
      icyc = cyc;
      issue(mode, frc);
      wait_evt(4, gd, ge, at);
      chk_eq("fast_cycle", at, icyc + 1);
      chk_eq(mode >= NM ? "illegal_err" : "skip_done", mode >= NM ? ge : gd, 1);
      repeat (5) step();
      chk_eq("fast_no_writes", obs_q.size(), 0);
      chk_eq("fast_busy", busy, 0);
      chk_eq("fast_cur_mode", cur_mode, m_cur);
    end else begin
      do_seq(mode, frc, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit found, gd, ge;
    int at, s, f, dcyc;

    rst_n = 1'b0; req = 1'b0; force_req = 1'b0; mode_sel = '0; pll_locked = 1'b0;
    for (int m = 0; m < NM; m++) begin
      t_n[m] = 18'($urandom);
      t_m[m] = 18'($urandom);
      t_k[m] = $urandom;
      for (int c = 0; c < NC; c++) t_c[m][c] = 18'($urandom);
    end
    t_n[1] = 18'h10000; t_m[1] = 18'h00404; t_k[1] = 32'h9745BF27;
    t_c[1][0] = 18'h00404; t_c[1][1] = 18'h00202;
    cfg_table = '0;
    for (int m = 0; m < NM; m++) begin
      cfg_table[m*EW +: 18]      = t_n[m];
      cfg_table[m*EW + 18 +: 18] = t_m[m];
      cfg_table[m*EW + 36 +: 32] = t_k[m];
      for (int c = 0; c < NC; c++) cfg_table[m*EW + 68 + 18*c +: 18] = t_c[m][c];
    end

    repeat (3) step();
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_err", err, 0);
    chk_eq("rst_cur_mode", cur_mode, 0);
    chk_eq("rst_cfg_valid", cfg_valid, 0);
    chk_eq("rst_write", mif.mgmt_write, 0);
    chk_eq("rst_addr", mif.mgmt_address, 0);
    chk_eq("rst_data", mif.mgmt_writedata, 0);
    chk_eq("rst_read", mif.mgmt_read, 0);
    rst_n = 1'b1;
    step();

    // Reference sequence with no stalls: seven back-to-back writes.
    do_seq(1, 0, 0);
    chk_eq("first_wr_cycle", last_f - last_icyc, 1);
    chk_eq("wr_span", last_s - last_f, 6);

    do_req(1, 0);
    scramble = 1;
    do_req(1, 1);
    scramble = 0;

    // Three-cycle stall on the M write.
    m_stall_en = 1; m_stall_cnt = 0; m_cycles = 0;
    do_seq(0, 0, 0);
    m_stall_en = 0;
    chk_eq("m_hold_cycles", m_cycles, 4);
    chk_eq("m_stall_span", last_s - last_f, 9);

    do_seq(2, 0, 1);
    do_req(2, 0);
    do_seq(1, 1, 2);

    // Two requests while busy: only the latest survives.
    obs_q.delete();
    build_exp(2);
    pll_locked = 1'b0;
    issue(2, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mif.mgmt_write && mif.mgmt_address == 6'h05) found = 1; else step();
    end
    chk_eq("pend_saw_wr_c", found, 1);
    issue(0, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mif.mgmt_write && mif.mgmt_address == 6'h07) found = 1; else step();
    end
    chk_eq("pend_saw_wr_k", found, 1);
    issue(1, 0);
    collect(s, f);
    repeat (3) step();
    pll_locked = 1'b1;
    wait_evt(20, gd, ge, dcyc);
    chk_eq("pend_first_done", gd, 1);
    chk_eq("pend_first_mode", cur_mode, 2);
    m_cur = 2; m_valid = 1;
    pll_locked = 1'b0;
    build_exp(1);
    collect(s, f);
    chk_eq("pend_start_cycle", f, dcyc + 1);
    finish_lock(1, s, 0);
    repeat (30) step();
    chk_eq("pend_no_more_writes", obs_q.size(), 0);
    chk_eq("pend_idle", busy, 0);

    do_req(3, 0);

    for (int it = 0; it < 12; it++) begin
      stall_pct = $urandom_range(0, 40);
      do_req($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of the K write.
    stall_pct = 30;
    pll_locked = 1'b0;
    issue(0, 1);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mif.mgmt_write && mif.mgmt_address == 6'h07) found = 1; else step();
    end
    chk_eq("rst_saw_wr_k", found, 1);
    rst_n = 1'b0;
    step();
    chk_eq("midrst_write", mif.mgmt_write, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_cfg_valid", cfg_valid, 0);
    chk_eq("midrst_cur_mode", cur_mode, 0);
    chk_eq("midrst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    m_cur = 0; m_valid = 0;
    step();
    stall_pct = 0;
    do_req(1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
